// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one UDP transmit byte stream between NUM_REQ payload sources.
// Each frame is header bytes from header_gen, the granted payload, zero padding, then an idle gap.
module udp_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int HDR_BYTES   = 42,
    parameter int MIN_FRAME   = 60,
    parameter int MAX_PAYLOAD = 1472,
    parameter int IFG_CYCLES  = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*12-1:0]  req_len_i,
    output logic [NUM_REQ-1:0]     req_grant_o,
    input  logic [NUM_REQ*8-1:0]   pay_data_i,
    input  logic [NUM_REQ-1:0]     pay_valid_i,
    output logic [NUM_REQ-1:0]     pay_ready_o,
    output logic [11:0]            payload_bytes_o,
    input  logic [HDR_BYTES*8-1:0] header_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    output logic                   tx_last_o,
    input  logic                   tx_ready_i,
    output logic                   busy_o,
    output logic                   err_len_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [11:0] HDR_W = 12'(HDR_BYTES);
    localparam logic [11:0] MIN_W = 12'(MIN_FRAME);
    localparam logic [11:0] MAX_W = 12'(MAX_PAYLOAD);
    localparam logic [11:0] IFG_W = 12'(IFG_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_PAD, S_GAP} state_t;

    state_t             state, state_n;
    logic [11:0]        cnt, cnt_n;
    logic [11:0]        len, len_n;
    logic [NUM_REQ-1:0] grant, grant_n;
    logic [PTR_W-1:0]   rr, rr_n;
    logic [PTR_W-1:0]   gidx, gidx_n;
    logic               err_n;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [11:0]        win_len;
    logic [7:0]         hdr_byte;
    logic [7:0]         pay_data_g;
    logic               pay_valid_g;
    logic [11:0]        frame_bytes;
    logic               pad_needed;

    // Round-robin search starting at the rr pointer, plus the source muxes for the granted requester.
    always_comb begin
        int idx;
        found   = 1'b0;
        win     = '0;
        idx     = 0;
        win_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (win == PTR_W'(r)) win_len = req_len_i[12*r +: 12];
        end
        hdr_byte = '0;
        for (int k = 0; k < HDR_BYTES; k++) begin
            if (cnt == 12'(k)) hdr_byte = header_i[8*k +: 8];
        end
        pay_data_g  = '0;
        pay_valid_g = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gidx == PTR_W'(r)) begin
                pay_data_g  = pay_data_i[8*r +: 8];
                pay_valid_g = pay_valid_i[r];
            end
        end
    end

    assign frame_bytes = HDR_W + len;
    assign pad_needed  = (frame_bytes < MIN_W);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            cnt       <= '0;
            len       <= '0;
            grant     <= '0;
            rr        <= '0;
            gidx      <= '0;
            err_len_o <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            len       <= len_n;
            grant     <= grant_n;
            rr        <= rr_n;
            gidx      <= gidx_n;
            err_len_o <= err_n;
        end
    end

    // cnt is the frame byte index in HDR/PAY/PAD and the idle-cycle count in GAP.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        len_n       = len;
        grant_n     = grant;
        rr_n        = rr;
        gidx_n      = gidx;
        err_n       = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        tx_last_o   = 1'b0;
        pay_ready_o = '0;
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    grant_n      = '0;
                    grant_n[win] = 1'b1;
                    gidx_n       = win;
                    len_n        = (win_len > MAX_W) ? MAX_W : win_len;
                    err_n        = (win_len > MAX_W);
                    rr_n         = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
                    cnt_n        = '0;
                    state_n      = S_HDR;
                end
            end
            S_HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = hdr_byte;
                tx_last_o  = (cnt == HDR_W - 12'd1) && (len == '0) && !pad_needed;
                if (tx_ready_i) begin
                    cnt_n = cnt + 12'd1;
                    if (cnt == HDR_W - 12'd1) begin
                        if (len != '0) begin
                            state_n = S_PAY;
                        end else if (pad_needed) begin
                            state_n = S_PAD;
                        end else begin
                            state_n = S_GAP;
                            cnt_n   = '0;
                            grant_n = '0;
                        end
                    end
                end
            end
            S_PAY: begin
                tx_valid_o = pay_valid_g;
                tx_data_o  = pay_data_g;
                tx_last_o  = (cnt == frame_bytes - 12'd1) && !pad_needed;
                for (int r = 0; r < NUM_REQ; r++) begin
                    pay_ready_o[r] = (gidx == PTR_W'(r)) && tx_ready_i;
                end
                if (pay_valid_g && tx_ready_i) begin
                    cnt_n = cnt + 12'd1;
                    if (cnt == frame_bytes - 12'd1) begin
                        if (pad_needed) begin
                            state_n = S_PAD;
                        end else begin
                            state_n = S_GAP;
                            cnt_n   = '0;
                            grant_n = '0;
                        end
                    end
                end
            end
            S_PAD: begin
                tx_valid_o = 1'b1;
                tx_last_o  = (cnt == MIN_W - 12'd1);
                if (tx_ready_i) begin
                    if (cnt == MIN_W - 12'd1) begin
                        state_n = S_GAP;
                        cnt_n   = '0;
                        grant_n = '0;
                    end else begin
                        cnt_n = cnt + 12'd1;
                    end
                end
            end
            S_GAP: begin
                if (cnt >= IFG_W - 12'd1) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign req_grant_o     = grant;
    assign payload_bytes_o = len;
    assign busy_o          = (state != S_IDLE);

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Randomized bench for udp_tx_scheduler: a frame-level model predicts grant order and every
// emitted byte, and monitors track handshake, gap and pulse behaviour.
module tb_udp_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int HDR     = 42;
    localparam int MINF    = 60;
    localparam int MAXP    = 1472;
    localparam int IFG     = 12;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ*12-1:0] req_len_i;
    logic [NUM_REQ-1:0]    req_grant_o;
    logic [NUM_REQ*8-1:0]  pay_data_i;
    logic [NUM_REQ-1:0]    pay_valid_i;
    logic [NUM_REQ-1:0]    pay_ready_o;
    logic [11:0]           payload_bytes_o;
    logic [HDR*8-1:0]      header_i;
    logic [7:0]            tx_data_o;
    logic                  tx_valid_o;
    logic                  tx_last_o;
    logic                  tx_ready_i;
    logic                  busy_o;
    logic                  err_len_o;

    udp_tx_scheduler #(
        .NUM_REQ(NUM_REQ), .HDR_BYTES(HDR), .MIN_FRAME(MINF),
        .MAX_PAYLOAD(MAXP), .IFG_CYCLES(IFG)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_len_i(req_len_i), .req_grant_o(req_grant_o),
        .pay_data_i(pay_data_i), .pay_valid_i(pay_valid_i), .pay_ready_o(pay_ready_o),
        .payload_bytes_o(payload_bytes_o), .header_i(header_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o),
        .tx_ready_i(tx_ready_i), .busy_o(busy_o), .err_len_o(err_len_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  pay_mem [NUM_REQ][2048];
    logic [7:0]  hdr_tb [HDR];
    logic [11:0] req_len_tb [NUM_REQ];
    int          pcnt [NUM_REQ];
    bit          stall_en;
    bit          acc_now [NUM_REQ];

    logic [7:0]  rx_q[$];
    bit          rx_last_q[$];
    int          grant_q[$];
    int          plen_q[$];
    int          grant_gap_q[$];
    int          busy_gap_q[$];
    int          cyc, last_cyc, err_cnt, hold_viol, ungrant_viol, pay_ready_cnt;
    int          acc_cnt [NUM_REQ];

    logic [7:0]  exp_q[$];
    bit          exp_last_q[$];
    int          exp_grant_q[$];
    int          exp_plen_q[$];
    int          rr_model;
    int          rx_base, grant_base, gg_base, bg_base, err_base;
    int          passed, total;

    always_comb begin
        for (int k = 0; k < HDR; k++) header_i[8*k +: 8] = hdr_tb[k];
        for (int r = 0; r < NUM_REQ; r++) begin
            req_len_i[12*r +: 12] = req_len_tb[r];
            pay_data_i[8*r +: 8]  = pay_mem[r][pcnt[r] % 2048];
        end
    end

    // Monitor samples mid-cycle, when everything for the next edge is settled.
    initial begin
        logic [NUM_REQ-1:0] prev_grant;
        logic [7:0]         prev_data;
        bit                 prev_stalled, prev_busy;
        cyc = 0; last_cyc = -1; err_cnt = 0; hold_viol = 0; ungrant_viol = 0; pay_ready_cnt = 0;
        prev_grant = '0; prev_data = '0; prev_stalled = 0; prev_busy = 0;
        for (int r = 0; r < NUM_REQ; r++) begin acc_cnt[r] = 0; acc_now[r] = 0; end
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_grant = '0; prev_stalled = 0; prev_busy = 0;
                for (int r = 0; r < NUM_REQ; r++) acc_now[r] = 0;
            end else begin
                if (tx_valid_o && tx_ready_i) begin
                    rx_q.push_back(tx_data_o);
                    rx_last_q.push_back(tx_last_o);
                    if (tx_last_o) last_cyc = cyc;
                end
                if (prev_stalled && (!tx_valid_o || tx_data_o !== prev_data)) hold_viol++;
                prev_stalled = tx_valid_o && !tx_ready_i;
                prev_data    = tx_data_o;
                if ((pay_ready_o & ~req_grant_o) != '0) ungrant_viol++;
                if (pay_ready_o != '0) pay_ready_cnt++;
                if (err_len_o) err_cnt++;
                for (int r = 0; r < NUM_REQ; r++) begin
                    acc_now[r] = pay_valid_i[r] && pay_ready_o[r];
                    if (acc_now[r]) acc_cnt[r]++;
                end
                if (req_grant_o != '0 && prev_grant == '0) begin
                    for (int r = 0; r < NUM_REQ; r++) if (req_grant_o[r]) grant_q.push_back(r);
                    plen_q.push_back(int'(payload_bytes_o));
                    if (last_cyc >= 0) grant_gap_q.push_back(cyc - last_cyc);
                end
                if (prev_busy && !busy_o) busy_gap_q.push_back(cyc - last_cyc);
                prev_grant = req_grant_o;
                prev_busy  = busy_o;
            end
        end
    end

    // Payload producers and sink: valid is only withdrawn after acceptance.
    initial begin
        logic [NUM_REQ-1:0] prev_g;
        pay_valid_i = '0;
        tx_ready_i  = 1'b1;
        prev_g      = '0;
        for (int r = 0; r < NUM_REQ; r++) pcnt[r] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!rst_n) begin
                    pay_valid_i[r] = 1'b0;
                end else begin
                    if (req_grant_o[r] && !prev_g[r]) pcnt[r] = 0;
                    else if (acc_now[r]) pcnt[r]++;
                    if (req_grant_o[r]) req_valid_i[r] = 1'b0;
                    if (!req_grant_o[r]) pay_valid_i[r] = 1'b0;
                    else if (!(pay_valid_i[r] && !acc_now[r]))
                        pay_valid_i[r] = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
            tx_ready_i = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_g = req_grant_o;
        end
    end

    // Frame-level model: serve pending requesters in rotating order starting at the pointer.
    task automatic predict(input logic [NUM_REQ-1:0] mask);
        logic [NUM_REQ-1:0] pend;
        int r, len, tot;
        exp_q.delete(); exp_last_q.delete(); exp_grant_q.delete(); exp_plen_q.delete();
        pend = mask;
        while (pend != '0) begin
            r = -1;
            for (int i = 0; i < NUM_REQ; i++)
                if (r < 0 && pend[(rr_model + i) % NUM_REQ]) r = (rr_model + i) % NUM_REQ;
            len = (int'(req_len_tb[r]) > MAXP) ? MAXP : int'(req_len_tb[r]);
            tot = (HDR + len > MINF) ? HDR + len : MINF;
            for (int k = 0; k < tot; k++) begin
                if (k < HDR)            exp_q.push_back(hdr_tb[k]);
                else if (k < HDR + len) exp_q.push_back(pay_mem[r][k - HDR]);
                else                    exp_q.push_back(8'h00);
                exp_last_q.push_back(k == tot - 1);
            end
            exp_grant_q.push_back(r);
            exp_plen_q.push_back(len);
            pend[r]  = 1'b0;
            rr_model = (r + 1) % NUM_REQ;
        end
    endtask

    task automatic launch(input logic [NUM_REQ-1:0] mask);
        predict(mask);
        rx_base    = rx_q.size();
        grant_base = grant_q.size();
        gg_base    = grant_gap_q.size();
        bg_base    = busy_gap_q.size();
        err_base   = err_cnt;
        req_valid_i = req_valid_i | mask;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_valid_i == '0 && !busy_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic new_header();
        for (int k = 0; k < HDR; k++) hdr_tb[k] = 8'($urandom);
    endtask

    function automatic int first_diff();
        int n = rx_q.size() - rx_base;
        int m = (n < exp_q.size()) ? n : exp_q.size();
        for (int i = 0; i < m; i++)
            if (rx_q[rx_base + i] !== exp_q[i] || rx_last_q[rx_base + i] !== exp_last_q[i]) return i;
        if (n != exp_q.size()) return m;
        return -1;
    endfunction

    function automatic logic [8:0] rx_at(int i);
        if (i >= 0 && rx_base + i < rx_q.size()) return {rx_last_q[rx_base + i], rx_q[rx_base + i]};
        return 9'h1ff;
    endfunction

    function automatic logic [8:0] ex_at(int i);
        if (i >= 0 && i < exp_q.size()) return {exp_last_q[i], exp_q[i]};
        return 9'h1ff;
    endfunction

    function automatic int grant_order_diff();
        for (int i = 0; i < exp_grant_q.size(); i++) begin
            if (grant_base + i >= grant_q.size()) return i;
            if (grant_q[grant_base + i] != exp_grant_q[i] ||
                plen_q[grant_base + i] != exp_plen_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({req_grant_o, pay_ready_o, payload_bytes_o} !== '0)
            $display("[TB] FAIL reset_ctl got grant=%b ready=%b plen=%0d want all 0", req_grant_o, pay_ready_o, payload_bytes_o);
        else passed++;
        total++;
        if ({tx_valid_o, tx_last_o, tx_data_o} !== '0)
            $display("[TB] FAIL reset_tx got valid=%b last=%b data=%h want 0", tx_valid_o, tx_last_o, tx_data_o);
        else passed++;
        total++;
        if ({busy_o, err_len_o} !== 2'b00)
            $display("[TB] FAIL reset_status got busy=%b err=%b want 0", busy_o, err_len_o);
        else passed++;
        rst_n = 1'b1;
        rr_model = 0;
    endtask

    task automatic test_single();
        bit ok;
        int d, bg;
        stall_en = 0; new_header();
        req_len_tb[0] = 12'd100;
        @(negedge clk);
        launch(4'b0001);
        wait_done(2000, ok);
        total++; if (!ok) $display("[TB] FAIL single_timeout got busy=%b want idle", busy_o); else passed++;
        total++;
        if (rx_q.size() - rx_base != 142) $display("[TB] FAIL single_count got %0d want 142", rx_q.size() - rx_base);
        else passed++;
        d = first_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL single_data at %0d got %h want %h", d, rx_at(d), ex_at(d)); else passed++;
        d = grant_order_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL single_grant at %0d want r%0d len %0d", d, exp_grant_q[d], exp_plen_q[d]); else passed++;
        bg = (busy_gap_q.size() > bg_base) ? busy_gap_q[bg_base] : -1;
        total++;
        if (bg != IFG + 1) $display("[TB] FAIL single_gap got %0d want %0d", bg, IFG + 1); else passed++;
        total++;
        if (err_cnt - err_base != 0) $display("[TB] FAIL single_err got %0d want 0", err_cnt - err_base); else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d, g1, g2;
        stall_en = 0; new_header();
        for (int r = 0; r < NUM_REQ; r++) req_len_tb[r] = 12'($urandom_range(0, 120));
        @(negedge clk);
        launch(4'b1110);
        wait_done(4000, ok);
        total++; if (!ok) $display("[TB] FAIL b2b_timeout got busy=%b want idle", busy_o); else passed++;
        d = grant_order_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL b2b_order at %0d want r%0d len %0d", d, exp_grant_q[d], exp_plen_q[d]); else passed++;
        d = first_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL b2b_data at %0d got %h want %h", d, rx_at(d), ex_at(d)); else passed++;
        g1 = (grant_gap_q.size() > gg_base + 1) ? grant_gap_q[gg_base + 1] : -1;
        g2 = (grant_gap_q.size() > gg_base + 2) ? grant_gap_q[gg_base + 2] : -1;
        total++;
        if (g1 != IFG + 2 || g2 != IFG + 2)
            $display("[TB] FAIL b2b_gap got %0d,%0d want %0d", g1, g2, IFG + 2);
        else passed++;
        req_len_tb[1] = 12'($urandom_range(0, 120));
        req_len_tb[2] = 12'($urandom_range(0, 120));
        @(negedge clk);
        launch(4'b0110);
        wait_done(3000, ok);
        total++; if (!ok) $display("[TB] FAIL b2b2_timeout got busy=%b want idle", busy_o); else passed++;
        d = grant_order_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL b2b2_order at %0d want r%0d len %0d", d, exp_grant_q[d], exp_plen_q[d]); else passed++;
        d = first_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL b2b2_data at %0d got %h want %h", d, rx_at(d), ex_at(d)); else passed++;
    endtask

    task automatic test_len_zero();
        bit ok;
        int d, pr;
        stall_en = 0; new_header();
        req_len_tb[1] = 12'd0;
        pr = pay_ready_cnt;
        @(negedge clk);
        launch(4'b0010);
        wait_done(1000, ok);
        total++; if (!ok) $display("[TB] FAIL zero_timeout got busy=%b want idle", busy_o); else passed++;
        total++;
        if (rx_q.size() - rx_base != MINF) $display("[TB] FAIL zero_count got %0d want %0d", rx_q.size() - rx_base, MINF);
        else passed++;
        d = first_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL zero_data at %0d got %h want %h", d, rx_at(d), ex_at(d)); else passed++;
        total++;
        if (pay_ready_cnt != pr) $display("[TB] FAIL zero_pay_ready got %0d cycles want 0", pay_ready_cnt - pr); else passed++;
    endtask

    task automatic test_pad();
        bit ok;
        int d;
        stall_en = 0; new_header();
        req_len_tb[2] = 12'd5;
        req_len_tb[3] = 12'd18;
        @(negedge clk);
        launch(4'b1100);
        wait_done(2000, ok);
        total++; if (!ok) $display("[TB] FAIL pad_timeout got busy=%b want idle", busy_o); else passed++;
        total++;
        if (rx_q.size() - rx_base != 2 * MINF) $display("[TB] FAIL pad_count got %0d want %0d", rx_q.size() - rx_base, 2 * MINF);
        else passed++;
        d = first_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL pad_data at %0d got %h want %h", d, rx_at(d), ex_at(d)); else passed++;
        d = grant_order_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL pad_grant at %0d want r%0d len %0d", d, exp_grant_q[d], exp_plen_q[d]); else passed++;
    endtask

    task automatic test_saturate();
        bit ok;
        int d, acc0, pl;
        stall_en = 0; new_header();
        req_len_tb[0] = 12'd2000;
        acc0 = acc_cnt[0];
        @(negedge clk);
        launch(4'b0001);
        wait_done(4000, ok);
        total++; if (!ok) $display("[TB] FAIL sat_timeout got busy=%b want idle", busy_o); else passed++;
        total++;
        if (err_cnt - err_base != 1) $display("[TB] FAIL sat_err_pulses got %0d want 1", err_cnt - err_base); else passed++;
        pl = (plen_q.size() > grant_base) ? plen_q[grant_base] : -1;
        total++;
        if (pl != MAXP) $display("[TB] FAIL sat_plen got %0d want %0d", pl, MAXP); else passed++;
        total++;
        if (acc_cnt[0] - acc0 != MAXP) $display("[TB] FAIL sat_accepted got %0d want %0d", acc_cnt[0] - acc0, MAXP); else passed++;
        total++;
        if (rx_q.size() - rx_base != HDR + MAXP)
            $display("[TB] FAIL sat_count got %0d want %0d", rx_q.size() - rx_base, HDR + MAXP);
        else passed++;
        d = first_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL sat_data at %0d got %h want %h", d, rx_at(d), ex_at(d)); else passed++;
    endtask

    task automatic test_stall();
        bit ok;
        int d;
        stall_en = 1; new_header();
        for (int r = 0; r < NUM_REQ; r++) req_len_tb[r] = 12'($urandom_range(0, 300));
        @(negedge clk);
        launch(4'b1111);
        wait_done(20000, ok);
        total++; if (!ok) $display("[TB] FAIL stall_timeout got busy=%b want idle", busy_o); else passed++;
        d = grant_order_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL stall_order at %0d want r%0d len %0d", d, exp_grant_q[d], exp_plen_q[d]); else passed++;
        d = first_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL stall_data at %0d got %h want %h", d, rx_at(d), ex_at(d)); else passed++;
        total++;
        if (hold_viol != 0) $display("[TB] FAIL stall_hold got %0d violations want 0", hold_viol); else passed++;
        total++;
        if (ungrant_viol != 0) $display("[TB] FAIL stall_ungranted_ready got %0d want 0", ungrant_viol); else passed++;
        stall_en = 0;
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int d, lasts;
        stall_en = 0; new_header();
        req_len_tb[1] = 12'd200;
        @(negedge clk);
        launch(4'b0010);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = pay_ready_o[1];
        end
        total++; if (!seen) $display("[TB] FAIL midrst_reach_pay got ready=%b want 1", pay_ready_o[1]); else passed++;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({req_grant_o, pay_ready_o, payload_bytes_o, busy_o, err_len_o} !== '0)
            $display("[TB] FAIL midrst_ctl got grant=%b ready=%b plen=%0d busy=%b want 0", req_grant_o, pay_ready_o, payload_bytes_o, busy_o);
        else passed++;
        total++;
        if ({tx_valid_o, tx_last_o, tx_data_o} !== '0)
            $display("[TB] FAIL midrst_tx got valid=%b last=%b data=%h want 0", tx_valid_o, tx_last_o, tx_data_o);
        else passed++;
        lasts = 0;
        for (int i = rx_base; i < rx_q.size(); i++) if (rx_last_q[i]) lasts++;
        total++; if (lasts != 0) $display("[TB] FAIL midrst_last got %0d want 0", lasts); else passed++;
        req_valid_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rr_model = 0;
        req_len_tb[0] = 12'd10;
        req_len_tb[3] = 12'd30;
        @(negedge clk);
        launch(4'b1001);
        wait_done(2000, ok);
        total++; if (!ok) $display("[TB] FAIL midrst_timeout got busy=%b want idle", busy_o); else passed++;
        d = grant_order_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL midrst_order at %0d want r%0d len %0d", d, exp_grant_q[d], exp_plen_q[d]); else passed++;
        d = first_diff();
        total++;
        if (d >= 0) $display("[TB] FAIL midrst_data at %0d got %h want %h", d, rx_at(d), ex_at(d)); else passed++;
    endtask

    initial begin
        passed = 0; total = 0; rr_model = 0; stall_en = 0;
        req_valid_i = '0;
        rst_n = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_len_tb[r] = '0;
            for (int i = 0; i < 2048; i++) pay_mem[r][i] = 8'($urandom);
        end
        for (int k = 0; k < HDR; k++) hdr_tb[k] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_len_zero();
        test_pad();
        test_saturate();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
